// File: rtl/nanov_periph_pkg.sv
// rtl/nanov_periph_pkg.sv - shared register map, TX state type and bit helpers for the nanoV store peripherals
package nanov_periph_pkg;

  localparam logic [31:0] PERIPH_GPIO_ADDR      = 32'h8000_0000;
  localparam logic [31:0] PERIPH_UART_DATA_ADDR = 32'h8000_0004;
  localparam logic [31:0] PERIPH_UART_CTRL_ADDR = 32'h8000_0008;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } uart_tx_state_t;

  // The CPU drives store data bit-reversed; data bit i sits on bus bit 31-i.
  // Only the low byte of the store data has a destination, so only the top
  // bus byte is ever un-reversed.
  function automatic logic [7:0] bit_reverse8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

endpackage

// File: rtl/nanov_uart_tx.sv
// rtl/nanov_uart_tx.sv - FIFO-buffered 8N1 UART transmitter with sticky overflow flag
module nanov_uart_tx
  import nanov_periph_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       clr_ovf,
  output logic       uart_tx,
  output logic       busy,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [AW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  uart_tx_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shreg_q, shreg_d;
  logic           tx_q, tx_d, busy_q, busy_d, ovf_q, ovf_d;
  logic           fifo_empty, fifo_full, pop, push_ok;

  // Pointer MSBs differ only when the writer has lapped the reader.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = (state_q == TX_IDLE) && !fifo_empty;
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign push_ok    = push && (!fifo_full || pop);

  // FIFO storage, written at the write pointer; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  // Next-state logic for pointers, overflow flag, TX FSM and registered outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    wr_ptr_d  = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d  = rd_ptr_q + (AW+1)'(pop);
    ovf_d     = ovf_q;
    if (push && !push_ok) ovf_d = 1'b1;
    else if (clr_ovf)     ovf_d = 1'b0;

    case (state_q)
      TX_IDLE: begin
        if (pop) begin
          shreg_d = mem_q[rd_ptr_q[AW-1:0]];
          cnt_d   = CNT_RELOAD;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (cnt_q == '0) begin
          cnt_d     = CNT_RELOAD;
          bit_idx_d = 3'd0;
          state_d   = TX_DATA;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      TX_DATA: begin
        if (cnt_q == '0) begin
          cnt_d     = CNT_RELOAD;
          shreg_d   = {1'b0, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = TX_STOP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      TX_STOP: begin
        if (cnt_q == '0) state_d = TX_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = TX_IDLE;
    endcase

    // Line level and busy are derived from next state so they leave a flop.
    case (state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shreg_d[0];
      default:  tx_d = 1'b1;
    endcase
    busy_d = (wr_ptr_d != rd_ptr_d) || (state_d != TX_IDLE);
  end

  // State registers; reset aborts any frame and empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= TX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
    end
  end

  assign uart_tx  = tx_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/nanov_store_periph.sv
// rtl/nanov_store_periph.sv - nanoV store snooper: address latch, data un-reversal and GPIO/UART decode
module nanov_store_periph
  import nanov_periph_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        store_addr_in,
  input  logic        store_data_in,
  output logic [7:0]  gpio_out,
  output logic        uart_tx,
  output logic        uart_busy,
  output logic        uart_overflow
);

  logic [31:0] addr_q, addr_d;
  logic        addr_valid_q, addr_valid_d;
  logic [7:0]  gpio_q, gpio_d;
  logic [7:0]  wdata;
  logic        data_fire, uart_push, uart_clr_ovf;

  assign wdata        = bit_reverse8(data_in[31:24]);
  assign data_fire    = store_data_in && addr_valid_q;
  // Decode always uses the previously latched address, even when a new
  // address strobe arrives on the same edge.
  assign uart_push    = data_fire && (addr_q == PERIPH_UART_DATA_ADDR);
  assign uart_clr_ovf = data_fire && (addr_q == PERIPH_UART_CTRL_ADDR) && wdata[0];

  // Address latch and GPIO register next-state.
  always_comb begin
    addr_d       = addr_q;
    addr_valid_d = addr_valid_q;
    gpio_d       = gpio_q;
    if (data_fire && (addr_q == PERIPH_GPIO_ADDR)) gpio_d = wdata;
    if (store_addr_in) begin
      addr_d       = data_in;
      addr_valid_d = 1'b1;
    end else if (data_fire) begin
      addr_valid_d = 1'b0;
    end
  end

  // Registers for address capture and GPIO output.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      gpio_q       <= '0;
    end else begin
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      gpio_q       <= gpio_d;
    end
  end

  assign gpio_out = gpio_q;

  nanov_uart_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) u_uart_tx (
    .clk       (clk),
    .rst       (rst),
    .push      (uart_push),
    .push_data (wdata),
    .clr_ovf   (uart_clr_ovf),
    .uart_tx   (uart_tx),
    .busy      (uart_busy),
    .overflow  (uart_overflow)
  );

endmodule
